mem_requester: RTL and testbench

Initiator side of the CPU memory interface: takes single load/store requests from the core and drives the valid/ready request and read-return handshake into `memory`. It holds at most one transaction outstanding and returns exactly one response per request. A read that stalls too long gets a timeout error response. It sits between the core's load/store path and the `memory` block.

---
 rtl/mem_requester.sv | 170 +++++++++++++++++
 tb/tb_mem_requester.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_requester.sv
// mem_requester: initiator side of the CPU memory interface.
// Accepts one load/store from the core and runs the request handshake into
// memory. For reads it also waits for the read return, or issues an error
// response on timeout. At most one transaction is in flight, and each request
// gets exactly one response.

package cpu_pkg;
  localparam int MEMORY_ADDR_WIDTH = 16;
  localparam int MEMORY_DATA_WIDTH = 32;

  typedef logic [MEMORY_ADDR_WIDTH-1:0] memory_address_t;
  typedef logic [MEMORY_DATA_WIDTH-1:0] memory_data_t;

  typedef enum logic {
    MEM_MODE_READ  = 1'b0,
    MEM_MODE_WRITE = 1'b1
  } memory_mode_t;
endpackage

module mem_requester
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  memory_address_t i_req_addr,
  input  memory_mode_t    i_req_mode,
  input  memory_data_t    i_req_wr_data,
  output logic            o_rsp_valid,
  output memory_data_t    o_rsp_rd_data,
  output logic            o_rsp_error,
  output logic            o_stray_rd,
  output logic            o_mem_valid,
  input  logic            i_mem_ready,
  output memory_address_t o_mem_addr,
  output memory_mode_t    o_mem_mode,
  output memory_data_t    o_mem_wr_data,
  input  logic            i_mem_rd_valid,
  input  memory_data_t    i_mem_rd_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RD,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture_req;
  logic             load_rsp;
  memory_data_t     rsp_data_d;
  logic             rsp_err_d;
  logic             stray_hit;
  logic             rd_handshake;

  // A read handshake in REQ is the only REQ-cycle case where rd_valid is expected
  assign rd_handshake = (state_q == S_REQ) && i_mem_ready && (o_mem_mode == MEM_MODE_READ);

  assign o_req_ready  = (state_q == S_IDLE) && !i_rst;
  assign o_mem_valid  = (state_q == S_REQ);
  assign o_rsp_valid  = (state_q == S_RESP);

  // Next-state, counter and response-load decisions
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture_req = 1'b0;
    load_rsp    = 1'b0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    stray_hit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        stray_hit = i_mem_rd_valid;
        if (i_req_valid) begin
          capture_req = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        stray_hit = i_mem_rd_valid && !rd_handshake;
        if (i_mem_ready) begin
          if (o_mem_mode == MEM_MODE_WRITE) begin
            load_rsp = 1'b1;
            state_d  = S_RESP;
          end else if (i_mem_rd_valid) begin
            // zero-latency memory returns data in the handshake cycle
            load_rsp   = 1'b1;
            rsp_data_d = i_mem_rd_data;
            state_d    = S_RESP;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT_RD;
          end
        end
      end
      S_WAIT_RD: begin
        if (i_mem_rd_valid) begin
          load_rsp   = 1'b1;
          rsp_data_d = i_mem_rd_data;
          state_d    = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          load_rsp  = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        stray_hit = i_mem_rd_valid;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and timeout counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory request registers: loaded on core accept, held through REQ
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mem_addr    <= '0;
      o_mem_mode    <= MEM_MODE_READ;
      o_mem_wr_data <= '0;
    end else if (capture_req) begin
      o_mem_addr    <= i_req_addr;
      o_mem_mode    <= i_req_mode;
      o_mem_wr_data <= i_req_wr_data;
    end
  end

  // Response payload: updated only when entering RESP, held until the next one
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_rd_data <= '0;
      o_rsp_error   <= 1'b0;
    end else if (load_rsp) begin
      o_rsp_rd_data <= rsp_data_d;
      o_rsp_error   <= rsp_err_d;
    end
  end

  // Sticky flag for read returns that arrive when none is expected
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stray_rd <= 1'b0;
    end else if (stray_hit) begin
      o_stray_rd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: table of directed transactions plus hand-written
// sequences for reset, stray returns and reset in the middle of a read.

module tb_mem_requester;
  import cpu_pkg::*;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  memory_address_t req_addr;
  memory_mode_t    req_mode;
  memory_data_t    req_wr_data;
  logic            rsp_valid;
  memory_data_t    rsp_rd_data;
  logic            rsp_error;
  logic            stray_rd;
  logic            mem_valid;
  logic            mem_ready;
  memory_address_t mem_addr;
  memory_mode_t    mem_mode;
  memory_data_t    mem_wr_data;
  logic            mem_rd_valid;
  memory_data_t    mem_rd_data;

  int total = 0;
  int bad   = 0;

  mem_requester #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_addr    (req_addr),
    .i_req_mode    (req_mode),
    .i_req_wr_data (req_wr_data),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_rd_data (rsp_rd_data),
    .o_rsp_error   (rsp_error),
    .o_stray_rd    (stray_rd),
    .o_mem_valid   (mem_valid),
    .i_mem_ready   (mem_ready),
    .o_mem_addr    (mem_addr),
    .o_mem_mode    (mem_mode),
    .o_mem_wr_data (mem_wr_data),
    .i_mem_rd_valid(mem_rd_valid),
    .i_mem_rd_data (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bp: cycles of backpressure before i_mem_ready.
  // rd_lat: rd_valid asserted rd_lat cycles after the handshake cycle (-1 = never).
  // exp_lat: cycle (after the accept edge) in which o_rsp_valid is high.
  typedef struct {
    memory_mode_t mode;
    logic [15:0]  addr;
    logic [31:0]  wdata;
    int           bp;
    int           rd_lat;
    logic [31:0]  rdata;
    logic [31:0]  exp_data;
    logic         exp_err;
    int           exp_lat;
    logic         exp_stray;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid    = 1'b0;
    req_addr     = '0;
    req_mode     = MEM_MODE_READ;
    req_wr_data  = '0;
    mem_ready    = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = 32'hFFFF_FFFF;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_mode"}, {31'd0, mem_mode}, {31'd0, MEM_MODE_READ});
    chk({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rd_data"}, rsp_rd_data, 32'd0);
    chk({tag, "_rsp_error"}, {31'd0, rsp_error}, 32'd0);
    chk({tag, "_stray_rd"}, {31'd0, stray_rd}, 32'd0);
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int lat;
    int nrsp;
    int mv_bad;
    logic [31:0] data;
    logic err;
    lat = -1; nrsp = 0; mv_bad = 0; data = '0; err = 1'b0;
    @(negedge clk);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_addr    = v.addr;
    req_mode    = v.mode;
    req_wr_data = v.wdata;
    @(posedge clk);
    #1;
    idle_inputs();
    for (int cyc = 1; cyc <= 12; cyc++) begin
      mem_ready    = (cyc == v.bp + 1);
      mem_rd_valid = (v.rd_lat >= 0) && (cyc == v.bp + 1 + v.rd_lat);
      mem_rd_data  = mem_rd_valid ? v.rdata : 32'hFFFF_FFFF;
      @(negedge clk);
      if (mem_valid !== (cyc <= v.bp + 1)) mv_bad++;
      if (mem_valid && (mem_addr !== v.addr || mem_mode !== v.mode || mem_wr_data !== v.wdata))
        mv_bad++;
      if (rsp_valid) begin
        nrsp++;
        if (lat < 0) begin
          lat  = cyc;
          data = rsp_rd_data;
          err  = rsp_error;
        end
      end
      @(posedge clk);
      #1;
      idle_inputs();
    end
    chk({tag, "_mem_req"}, mv_bad, 0);
    chk({tag, "_rsp_count"}, nrsp, 1);
    chk({tag, "_rsp_lat"}, lat, v.exp_lat);
    chk({tag, "_rsp_data"}, data, v.exp_data);
    chk({tag, "_rsp_err"}, {31'd0, err}, {31'd0, v.exp_err});
    chk({tag, "_rsp_hold"}, rsp_rd_data, v.exp_data);
    chk({tag, "_stray"}, {31'd0, stray_rd}, {31'd0, v.exp_stray});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[7];
  vec_t wr_after_stray;

  initial begin
    rst = 1'b1;
    idle_inputs();

    vecs[0] = '{MEM_MODE_WRITE, 16'h0010, 32'h0000_00A5, 0, -1, 32'h0, 32'h0,         1'b0, 2, 1'b0};
    vecs[1] = '{MEM_MODE_READ,  16'h0020, 32'h0,         2,  3, 32'h5C, 32'h5C,      1'b0, 7, 1'b0};
    vecs[2] = '{MEM_MODE_READ,  16'h0030, 32'h0,         0,  0, 32'h77, 32'h77,      1'b0, 2, 1'b0};
    vecs[3] = '{MEM_MODE_READ,  16'h0040, 32'h0,         0,  4, 32'h3C, 32'h3C,      1'b0, 6, 1'b0};
    vecs[4] = '{MEM_MODE_READ,  16'h0050, 32'h0,         1,  1, 32'h1234, 32'h1234,  1'b0, 4, 1'b0};
    vecs[5] = '{MEM_MODE_WRITE, 16'h0060, 32'hDEAD_BEEF, 3, -1, 32'h0, 32'h0,         1'b0, 5, 1'b0};
    vecs[6] = '{MEM_MODE_READ,  16'h0044, 32'h0,         0,  5, 32'h99, 32'h0,        1'b1, 6, 1'b1};

    // reset state while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i]);
    end

    // stray return while IDLE, then a normal write
    do_reset();
    @(negedge clk);
    chk("stray_clear", {31'd0, stray_rd}, 32'd0);
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'h4242_4242;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    chk("stray_set", {31'd0, stray_rd}, 32'd1);
    chk("stray_state_idle", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("stray_sticky", {31'd0, stray_rd}, 32'd1);
    wr_after_stray = '{MEM_MODE_WRITE, 16'h0070, 32'h0000_1111, 0, -1, 32'h0, 32'h0, 1'b0, 2, 1'b1};
    run_txn("wr_after_stray", wr_after_stray);

    // reset while in WAIT_RD
    @(negedge clk);
    req_valid   = 1'b1;
    req_addr    = 16'h0080;
    req_mode    = MEM_MODE_READ;
    req_wr_data = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    chk("midrd_mem_valid", {31'd0, mem_valid}, 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("midrd_in_wait", {31'd0, mem_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrd");
    rst = 1'b0;
    mem_rd_valid = 1'b0;
    @(negedge clk);
    chk("midrd_ready_after", {31'd0, req_ready}, 32'd1);
    chk("midrd_no_rsp", {31'd0, rsp_valid}, 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("midrd_quiet", {31'd0, rsp_valid | mem_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
